// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: one bit per cycle, done pulses XLEN+1 cycles after start.
// No backpressure: start is taken only when idle; flush aborts an in-flight op leaving HI/LO untouched.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            dbz,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d, neg_q, neg_d, siga_q, siga_d, bz_q, bz_d;
    logic [XLEN-1:0] a_q, a_d, opnd_q, opnd_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d, dbz_q, dbz_d;

    logic            a_neg, b_neg, div_ge;
    logic [XLEN-1:0] a_mag, b_mag, div_sub, quo_fix, rem_fix;
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [2*XLEN-1:0] prod, prod_fix;

    // acc_hi/acc_lo hold {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        a_neg    = ~op[0] & a[XLEN-1];
        b_neg    = ~op[0] & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge   = (rem_sh >= {1'b0, opnd_q});
        div_sub  = rem_sh[XLEN-1:0] - opnd_q;
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = siga_q ? -acc_hi_q : acc_hi_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        siga_d   = siga_q;
        bz_d     = bz_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    siga_d   = a_neg;
                    bz_d     = (b == '0);
                    a_d      = a;
                    acc_hi_d = '0;
                    acc_lo_d = op[1] ? a_mag : b_mag;
                    opnd_d   = op[1] ? b_mag : a_mag;
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ge ? div_sub : rem_sh[XLEN-1:0];
                        acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[XLEN:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (bz_q) begin
                        lo_d  = '1;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            siga_q   <= 1'b0;
            bz_q     <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            siga_q   <= siga_d;
            bz_q     <= bz_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit; expected HI/LO/dbz are queued at issue and
// popped by an independent monitor whenever done is seen.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, flush, wr_hi, wr_lo;
    logic [1:0]      op;
    logic [XLEN-1:0] a, b, wdata;
    logic            busy, done, dbz;
    logic [XLEN-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [2*XLEN:0] exp_q[$];
    logic [2*XLEN:0] exp_e;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the architecture
    function automatic logic [2*XLEN:0] model(input logic [1:0] o, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        longint            sx, sy;
        logic              z;
        z  = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'd0: p = sx * sy;
            2'd1: p = {32'b0, x} * {32'b0, y};
            default: begin
                if (y == 0) begin
                    q = '1; r = x; z = 1'b1;
                end else if (o == 2'd2) begin
                    q = 32'(sx / sy);
                    r = 32'(sx % sy);
                end else begin
                    q = x / y;
                    r = x % y;
                end
                p = {r, q};
            end
        endcase
        return {z, p};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("hi", hi, exp_e[63:32]);
                    check("lo", lo, exp_e[31:0]);
                    check("dbz", dbz, exp_e[64]);
                    check("busy_at_done", busy, 0);
                end
            end else if (!reset && dbz) begin
                check("dbz_without_done", 1, 0);
            end
        end
    end

    // Issues an op now (caller is away from the edge) and returns #1 after the done edge
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input bit poke);
        int n, bc;
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        bc = busy ? 1 : 0;
        n = 0;
        while (!done && n < 40) begin
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        check("latency", n, 33);
        check("busy_cycles", bc, 33);
    endtask

    initial begin
        logic [1:0]      ro;
        logic [XLEN-1:0] rx, ry;
        reset = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'd0; a = '0; b = '0; wdata = '0;
        #12;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 1'b0);
        run_op(2'd2, 32'h0000_1234, 32'd0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd0, $urandom, $urandom, 1'b1);
        @(posedge clk); #1;

        wdata = 32'hABCD; wr_hi = 1'b1;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        check("wr_hi_idle", hi, 32'hABCD);
        wdata = 32'h11; wr_hi = 1'b1;
        @(posedge clk); #1;
        wr_hi = 1'b0; wdata = 32'h22; wr_lo = 1'b1;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        check("wr_hi_11", hi, 32'h11);
        check("wr_lo_22", lo, 32'h22);

        // flush with start in IDLE: not accepted
        op = 2'd0; a = 32'd5; b = 32'd6; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", busy, 0);

        // start with a simultaneous write (write dropped), writes while busy, flush at iteration 10
        op = 2'd0; a = 32'd9; b = 32'd9; start = 1'b1; wdata = 32'h55; wr_hi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        wdata = 32'h99; wr_lo = 1'b1; wr_hi = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wr_lo = 1'b0; wr_hi = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
        repeat (3) @(posedge clk);
        #1;
        check("flush_hi_later", hi, 32'h11);
        check("flush_busy_later", busy, 0);

        // asynchronous reset mid-RUN
        op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_op(2'd1, 32'd123456, 32'd789, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = '0;
                1: begin rx = 32'h8000_0000; ry = '1; end
                2: ry = 32'($urandom_range(1, 15));
                3: rx = 32'($urandom_range(0, 300));
                default: ;
            endcase
            run_op(ro, rx, ry, i[2]);
        end
        @(posedge clk); #1;
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage. It replaces the single-cycle combinational MUL path in the ALU.
- Supports signed and unsigned MULT and DIV, with results held in architectural HI/LO registers.
- Reports busy to the hazard logic so the pipeline stalls dependent HI/LO reads.
- Accepts a pipeline flush so that an op issued under a taken branch is aborted.

Parameters:
- XLEN, 32, operand width. HI and LO are each XLEN bits. Must be ≥4 and even.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  issue request; sampled only in IDLE
- op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- a  in  XLEN  operand A (multiplicand / dividend)
- b  in  XLEN  operand B (multiplier / divisor)
- flush  in  1  abort the in-flight op
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wdata  in  XLEN  MTHI/MTLO data
- busy  out  1  op in flight (RUN or FIX)
- done  out  1  one-cycle pulse when HI/LO are updated by an op
- dbz  out  1  one-cycle pulse, coincident with done, on divide by zero
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- Reset (asynchronous, takes effect immediately, including mid-op):
  - state=IDLE
  - hi, lo, busy, done, dbz = 0
  - all internal accumulators cleared
- FSM states: IDLE, RUN, FIX.
  - IDLE → RUN on an edge where start=1 and flush=0. The edge latches op, a, b, and the absolute values/signs for signed ops.
  - RUN iterates 1 bit per edge for exactly XLEN edges (iteration counter 0..XLEN-1), then goes to FIX.
  - FIX applies the sign correction, writes hi/lo, pulses done, and returns to IDLE.
- Latency: start sampled at edge E0. busy=1 after E0. hi/lo updated and done=1 after edge E(XLEN+1). busy=0 in the same cycle as done.
- Back-to-back: a start present during the done cycle is accepted; the next op begins.
- Multiply: shift-add on magnitudes producing a 2·XLEN-bit product; {hi,lo}=product. Signed: negate the 2·XLEN product if the operand signs differ.
- Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
  - Signed: negate the quotient if the operand signs differ.
  - Signed: the remainder takes the dividend's sign.
- Division special cases (full latency still applies; results are deterministic):
  - b==0 (either div op): lo=all ones, hi=a, dbz=1 with done.
  - DIV signed with a=MIN and b=-1: lo=MIN, hi=0, dbz=0.
- flush:
  - In RUN or FIX: state→IDLE on that edge; hi/lo unchanged; no done. busy=0 the following cycle.
  - flush with start in IDLE: flush wins and the op is not accepted.
- start while busy: ignored; operands are not resampled.
- wr_hi/wr_lo: write on the edge only when state=IDLE and no op is accepted on that edge. They are ignored while busy or when start is accepted on the same edge.
- Priority on an IDLE edge: reset > flush > start > wr_hi/wr_lo.
- Arithmetic wraps modulo 2^XLEN per register. No other overflow flags.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done 1 cycle; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed and unsigned divide:
  - DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then a DIVU a=100, b=7 issued in the done cycle → lo=14, hi=2, done exactly 33 edges later.
- Division special cases:
  - DIV a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, dbz=1 with done.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0.
- Flush and ignored inputs:
  - With hi=0x11, lo=0x22, start MULT then assert flush at iteration 10 → busy=0 next cycle, no done, hi/lo stay 0x11/0x22.
  - start pulsed mid-op is ignored (result matches the original operands).
  - wr_lo while busy is ignored.
- Reset and IDLE writes:
  - Assert reset asynchronously mid-RUN → hi=lo=0, busy=0 immediately; the next start runs normally.
  - wr_hi with wdata=0xABCD in IDLE → hi=0xABCD on the next edge.
